// File: rtl/event_merge_control.sv
// event_merge_control: drains enabled channel FIFOs in order 0..N_CH-1 up to each end-event word,
// then writes one merged end-event word carrying the first channel's tag.
module event_merge_control #(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 21,
    parameter int TIMEOUT = 1023
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic [N_CH-1:0]        CH_ENABLE,
    input  logic [N_CH-1:0]        IN_EMPTY,
    input  logic [N_CH*DATA_W-1:0] IN_DATA,
    output logic [N_CH-1:0]        IN_RE,
    input  logic                   OUT_FIFO_FULL,
    output logic                   OUT_FIFO_WE,
    output logic [DATA_W-1:0]      OUT_DATA,
    output logic [2:0]             SEL,
    output logic                   EVENT_DONE,
    output logic                   TAG_ERROR,
    output logic                   TIMEOUT_ERROR,
    input  logic                   CLEAR_ERR
);
    localparam logic [1:0] IDLE = 2'd0, XFER = 2'd1, NEXT = 2'd2, EMIT = 2'd3;
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [N_CH-1:0]   en_mask;
    logic [7:0]        tag;
    logic              tag_valid;
    logic [9:0]        wait_cnt;
    logic [DATA_W-1:0] head;
    logic              head_empty, head_ee, pop, timed_out, tag_mis, has_next;
    logic [2:0]        first_sel, next_sel;

    // descending scan so the last hit is the lowest qualifying channel
    always_comb begin
        head       = '0;
        head_empty = 1'b1;
        first_sel  = '0;
        next_sel   = '0;
        has_next   = 1'b0;
        IN_RE      = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (SEL == 3'(i)) begin
                head       = IN_DATA[i*DATA_W +: DATA_W];
                head_empty = IN_EMPTY[i];
            end
            if (CH_ENABLE[i]) first_sel = 3'(i);
            if (en_mask[i] && 3'(i) > SEL) begin
                next_sel = 3'(i);
                has_next = 1'b1;
            end
        end
        for (int i = 0; i < N_CH; i++) IN_RE[i] = pop && SEL == 3'(i);
    end

    assign head_ee     = head[DATA_W-1];
    assign pop         = state == XFER && !head_empty && !OUT_FIFO_FULL;
    assign timed_out   = state == XFER && head_empty && wait_cnt == TO_LAST;
    assign tag_mis     = pop && head_ee && tag_valid && head[7:0] != tag;
    assign EVENT_DONE  = state == EMIT && !OUT_FIFO_FULL;
    assign OUT_FIFO_WE = (pop && !head_ee) || EVENT_DONE;
    assign OUT_DATA    = EVENT_DONE ? {1'b1, {(DATA_W-9){1'b0}}, tag} : (OUT_FIFO_WE ? head : '0);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            en_mask       <= '0;
            SEL           <= '0;
            tag           <= '0;
            tag_valid     <= 1'b0;
            wait_cnt      <= '0;
            TAG_ERROR     <= 1'b0;
            TIMEOUT_ERROR <= 1'b0;
        end else begin
            TAG_ERROR     <= tag_mis || (TAG_ERROR && !CLEAR_ERR);
            TIMEOUT_ERROR <= timed_out || (TIMEOUT_ERROR && !CLEAR_ERR);
            case (state)
                IDLE: begin
                    en_mask <= CH_ENABLE;
                    if (|CH_ENABLE) begin
                        SEL       <= first_sel;
                        tag       <= '0;
                        tag_valid <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    wait_cnt <= pop ? '0 : (head_empty ? wait_cnt + 1'b1 : wait_cnt);
                    if (pop && head_ee && !tag_valid) begin
                        tag       <= head[7:0];
                        tag_valid <= 1'b1;
                    end
                    if ((pop && head_ee) || timed_out) state <= NEXT;
                end
                NEXT: begin
                    wait_cnt <= '0;
                    SEL      <= has_next ? next_sel : SEL;
                    state    <= has_next ? XFER : EMIT;
                end
                default: state <= OUT_FIFO_FULL ? EMIT : IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_event_merge_control.sv
// tb_event_merge_control: directed vectors against queue-modelled input FIFOs and a captured output stream.
module tb_event_merge_control;
    localparam int N = 4, W = 21;

    logic CLOCK = 1'b0, RESET = 1'b0, OUT_FIFO_FULL = 1'b0, CLEAR_ERR = 1'b0;
    logic [N-1:0] CH_ENABLE = '0, IN_EMPTY = '1, IN_RE;
    logic [N*W-1:0] IN_DATA = '0;
    logic OUT_FIFO_WE, EVENT_DONE, TAG_ERROR, TIMEOUT_ERROR;
    logic [W-1:0] OUT_DATA;
    logic [2:0] SEL;

    logic [W-1:0] chq [N][$];
    logic [W-1:0] oq [$];
    int n_tests = 0, n_fail = 0, done_cnt = 0, viol = 0, sel1_cycles = 0;
    int re_cnt [N] = '{default: 0};

    event_merge_control dut (
        .CLOCK(CLOCK), .RESET(RESET), .CH_ENABLE(CH_ENABLE), .IN_EMPTY(IN_EMPTY),
        .IN_DATA(IN_DATA), .IN_RE(IN_RE), .OUT_FIFO_FULL(OUT_FIFO_FULL),
        .OUT_FIFO_WE(OUT_FIFO_WE), .OUT_DATA(OUT_DATA), .SEL(SEL), .EVENT_DONE(EVENT_DONE),
        .TAG_ERROR(TAG_ERROR), .TIMEOUT_ERROR(TIMEOUT_ERROR), .CLEAR_ERR(CLEAR_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    // samples pre-edge outputs, then updates the FIFO models just after the edge
    always @(posedge CLOCK) begin
        logic [N-1:0] re;
        logic we;
        logic [W-1:0] od;
        re = IN_RE;
        we = OUT_FIFO_WE;
        od = OUT_DATA;
        if (OUT_FIFO_FULL && (re != 0 || we)) viol++;
        if ((re & IN_EMPTY) != 0) viol++;
        if (EVENT_DONE) done_cnt++;
        if (SEL == 3'd1) sel1_cycles++;
        if (we) oq.push_back(od);
        #1;
        for (int k = 0; k < N; k++) begin
            if (re[k]) begin
                re_cnt[k]++;
                if (chq[k].size() > 0) void'(chq[k].pop_front());
            end
            IN_EMPTY[k] = chq[k].size() == 0;
            IN_DATA[k*W +: W] = IN_EMPTY[k] ? '0 : chq[k][0];
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(int k, int n, logic [7:0] t);
        for (int i = 0; i < n; i++) chq[k].push_back(W'(k * 16 + i + 1));
        chq[k].push_back({1'b1, 12'd0, t});
    endtask

    task automatic start(logic [N-1:0] m);
        @(negedge CLOCK) CH_ENABLE = m;
        @(negedge CLOCK) CH_ENABLE = '0;
    endtask

    task automatic wait_done(int d0, int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge CLOCK);
        check("event_done_in_time", 32'(done_cnt != d0), 1);
        repeat (2) @(negedge CLOCK);
    endtask

    task automatic wait_sel(int s, int budget);
        for (int i = 0; i < budget && SEL != 3'(s); i++) @(negedge CLOCK);
        check($sformatf("reach_sel%0d", s), 32'(SEL), 32'(s));
    endtask

    task automatic check_stream(string tag, int base, logic [N-1:0] m, int n, logic [7:0] t);
        int j = base;
        check({tag, "_count"}, 32'(oq.size() - base), 32'($countones(m) * n + 1));
        for (int k = 0; k < N; k++)
            if (m[k])
                for (int i = 0; i < n; i++) begin
                    check({tag, "_data"}, 32'(j < oq.size() ? oq[j] : '1), 32'(k * 16 + i + 1));
                    j++;
                end
        check({tag, "_ee"}, 32'(j < oq.size() ? oq[j] : '1), 32'({1'b1, 12'd0, t}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b, d0, v0, s0, ee;
        int r0 [N];
        repeat (3) @(negedge CLOCK);
        check("rst_in_re", 32'(IN_RE), 0);
        check("rst_we", 32'(OUT_FIFO_WE), 0);
        check("rst_out_data", 32'(OUT_DATA), 0);
        check("rst_sel", 32'(SEL), 0);
        check("rst_done", 32'(EVENT_DONE), 0);
        check("rst_errs", 32'({TAG_ERROR, TIMEOUT_ERROR}), 0);
        RESET = 1'b1;

        // all four channels, matching tags
        b = oq.size(); d0 = done_cnt; v0 = viol;
        for (int k = 0; k < N; k++) load(k, 2, 8'h05);
        start(4'b1111);
        wait_done(d0, 200);
        check_stream("t1", b, 4'b1111, 2, 8'h05);
        check("t1_done_once", 32'(done_cnt - d0), 1);
        check("t1_errs", 32'({TAG_ERROR, TIMEOUT_ERROR}), 0);

        // masked channels must stay untouched
        b = oq.size(); d0 = done_cnt; r0 = re_cnt;
        for (int k = 0; k < N; k++) load(k, 2, 8'h05);
        start(4'b0101);
        wait_done(d0, 200);
        check_stream("t2", b, 4'b0101, 2, 8'h05);
        check("t2_re1", 32'(re_cnt[1] - r0[1]), 0);
        check("t2_re3", 32'(re_cnt[3] - r0[3]), 0);
        check("t2_ch1_left", 32'(chq[1].size()), 3);
        check("t2_ch3_left", 32'(chq[3].size()), 3);
        chq[1].delete();
        chq[3].delete();

        // tag mismatch on ch2
        b = oq.size(); d0 = done_cnt;
        load(0, 2, 8'h05); load(1, 2, 8'h05); load(2, 2, 8'h06); load(3, 2, 8'h05);
        start(4'b1111);
        wait_sel(2, 100);
        check("t3_tag_before_ch2", 32'(TAG_ERROR), 0);
        wait_sel(3, 100);
        check("t3_tag_after_ch2", 32'(TAG_ERROR), 1);
        wait_done(d0, 200);
        check_stream("t3", b, 4'b1111, 2, 8'h05);
        check("t3_tag_sticky", 32'(TAG_ERROR), 1);
        check("t3_no_timeout", 32'(TIMEOUT_ERROR), 0);
        @(negedge CLOCK) CLEAR_ERR = 1'b1;
        @(negedge CLOCK) CLEAR_ERR = 1'b0;
        check("t3_tag_cleared", 32'(TAG_ERROR), 0);

        // ch1 empty all event: 1023 waiting cycles plus the NEXT cycle with SEL=1
        b = oq.size(); d0 = done_cnt; s0 = sel1_cycles;
        load(0, 1, 8'h05); load(2, 1, 8'h05); load(3, 1, 8'h05);
        start(4'b1111);
        wait_sel(1, 50);
        check("t4_no_timeout_yet", 32'(TIMEOUT_ERROR), 0);
        wait_sel(2, 1100);
        check("t4_timeout_set", 32'(TIMEOUT_ERROR), 1);
        wait_done(d0, 200);
        check("t4_sel1_cycles", 32'(sel1_cycles - s0), 1024);
        check_stream("t4", b, 4'b1101, 1, 8'h05);
        check("t4_no_tag_err", 32'(TAG_ERROR), 0);
        @(negedge CLOCK) CLEAR_ERR = 1'b1;
        @(negedge CLOCK) CLEAR_ERR = 1'b0;
        check("t4_timeout_cleared", 32'(TIMEOUT_ERROR), 0);

        // backpressure mid-stream and during EMIT
        b = oq.size(); d0 = done_cnt; v0 = viol;
        for (int k = 0; k < N; k++) load(k, 2, 8'h05);
        start(4'b1111);
        repeat (2) @(negedge CLOCK);
        OUT_FIFO_FULL = 1'b1;
        repeat (5) @(negedge CLOCK);
        OUT_FIFO_FULL = 1'b0;
        for (int i = 0; i < 200 && !(IN_RE[3] && IN_DATA[3*W+W-1]); i++) @(negedge CLOCK);
        check("t5_ch3_ee_pop", 32'(IN_RE[3]), 1);
        @(negedge CLOCK) OUT_FIFO_FULL = 1'b1;
        repeat (5) @(negedge CLOCK);
        check("t5_emit_held", 32'(done_cnt - d0), 0);
        check("t5_we_while_full", 32'(OUT_FIFO_WE), 0);
        OUT_FIFO_FULL = 1'b0;
        wait_done(d0, 200);
        check_stream("t5", b, 4'b1111, 2, 8'h05);
        check("t5_violations", 32'(viol - v0), 0);
        check("t5_done_once", 32'(done_cnt - d0), 1);
        check("t5_no_timeout", 32'(TIMEOUT_ERROR), 0);

        // reset during ch1 transfer abandons the event
        b = oq.size(); d0 = done_cnt;
        for (int k = 0; k < N; k++) load(k, 2, 8'h05);
        start(4'b1111);
        for (int i = 0; i < 100 && !IN_RE[1]; i++) @(negedge CLOCK);
        check("t6_in_ch1", 32'(IN_RE[1]), 1);
        RESET = 1'b0;
        #1;
        check("t6_rst_in_re", 32'(IN_RE), 0);
        check("t6_rst_we", 32'(OUT_FIFO_WE), 0);
        check("t6_rst_out_data", 32'(OUT_DATA), 0);
        check("t6_rst_sel", 32'(SEL), 0);
        check("t6_rst_done", 32'(EVENT_DONE), 0);
        repeat (2) @(negedge CLOCK);
        RESET = 1'b1;
        repeat (2) @(negedge CLOCK);
        ee = 0;
        for (int j = b; j < oq.size(); j++) if (oq[j][W-1]) ee++;
        check("t6_no_partial_ee", 32'(ee), 0);
        check("t6_no_done", 32'(done_cnt - d0), 0);
        for (int k = 0; k < N; k++) chq[k].delete();
        b = oq.size(); d0 = done_cnt;
        for (int k = 0; k < N; k++) load(k, 1, 8'h09);
        start(4'b1111);
        wait_done(d0, 200);
        check_stream("t6", b, 4'b1111, 1, 8'h09);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/event_merge_control.md
Name: event_merge_control

Overview:
- Event-synchronous merger that shares one output FIFO between N_CH formatter output FIFOs.
- Drains each enabled channel in fixed order 0..N_CH-1 until that channel's end-event (EE) word, then writes one merged EE word downstream.
- Sits between the per-channel formatter_control output FIFOs and the board output FIFO.
- Drives the data-mux select, read enables and write enable.
- Detects event-tag mismatches and stalled channels.

Parameters:
- N_CH, 4, number of input channels (2..8)
- DATA_W, 21, word width; bit DATA_W-1 is EE flag, bits 7:0 of an EE word are the event tag
- TIMEOUT, 1023, cycles a selected channel may stay empty mid-event before being skipped (counter width 10 bits, TIMEOUT <= 1023)

Ports:
- CLOCK  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- CH_ENABLE  in  N_CH  channel participation mask, sampled at event start
- IN_EMPTY  in  N_CH  per-channel first-word-fall-through FIFO empty
- IN_DATA  in  N_CH*DATA_W  head words, channel k at bits [k*DATA_W +: DATA_W]
- IN_RE  out  N_CH  per-channel read enable (pop), one-hot or zero
- OUT_FIFO_FULL  in  1  output FIFO full
- OUT_FIFO_WE  out  1  output write enable
- OUT_DATA  out  DATA_W  output word, registered with OUT_FIFO_WE
- SEL  out  3  currently selected channel
- EVENT_DONE  out  1  one-cycle pulse when merged EE word is written
- TAG_ERROR  out  1  sticky: enabled channels' EE tags disagreed
- TIMEOUT_ERROR  out  1  sticky: a channel was skipped on timeout
- CLEAR_ERR  in  1  synchronous clear of both sticky errors

Behaviour:
- Reset (RESET=0, async): state IDLE, IN_RE=0, OUT_FIFO_WE=0, OUT_DATA=0, SEL=0, EVENT_DONE=0, TAG_ERROR=0, TIMEOUT_ERROR=0, mask/tag/timeout registers cleared. Reset mid-event abandons the event; no partial EE word is written.
- IDLE: latch CH_ENABLE into EN_MASK. If EN_MASK=0, stay. Otherwise SEL=lowest set bit, clear tag-valid, go XFER.
- XFER, transfer rule (IN_RE/OUT_FIFO_WE combinational from registered state):
  - Condition: !IN_EMPTY[SEL] && !OUT_FIFO_FULL.
  - Head EE=0: IN_RE[SEL]=1 and OUT_FIFO_WE=1 in the same cycle; OUT_DATA=head word. One word per cycle, zero added latency.
  - Head EE=1: IN_RE[SEL]=1, OUT_FIFO_WE=0 (EE word consumed, not forwarded).
    - First EE of the event: tag stored.
    - Later EE words: tag compared to stored tag; mismatch sets TAG_ERROR.
    - Then go NEXT.
  - Wait: IN_EMPTY[SEL]=1 increments the timeout counter; OUT_FIFO_FULL alone holds without counting. Counter clears on every pop and on entering XFER.
  - Counter reaching TIMEOUT sets TIMEOUT_ERROR and goes NEXT without popping.
- NEXT (1 cycle): select the next higher set bit in EN_MASK and return to XFER; if none remains, go EMIT.
- EMIT: when !OUT_FIFO_FULL, write OUT_FIFO_WE=1 with OUT_DATA = {EE=1, zeros, stored tag}; tag=0 if no channel delivered an EE. EVENT_DONE=1 that same cycle. Next state IDLE. Holds indefinitely while full.
- Simultaneous CLEAR_ERR and error set in the same cycle: set wins.
- CH_ENABLE changes mid-event are ignored until the next IDLE.
- Channels outside EN_MASK are never read.
- Per-event minimum overhead: 1 IDLE + 1 NEXT per enabled channel + 1 EMIT cycle.
- Never IN_RE on an empty channel; never OUT_FIFO_WE while OUT_FIFO_FULL=1.

Test Plan:
- CH_ENABLE=4'b1111; ch0..3 each hold 2 data words + EE tag 0x05 -> 8 data words out in order ch0,ch1,ch2,ch3, then one word EE=1 tag 0x05; EVENT_DONE pulses once; errors stay 0.
- CH_ENABLE=4'b0101, ch1 and ch3 also loaded -> only ch0 and ch2 read (IN_RE[1], IN_RE[3] never high); ch1/ch3 contents untouched.
- ch2 EE tag 0x06, others 0x05 -> TAG_ERROR=1 after ch2's EE pop; merged EE carries 0x05; CLEAR_ERR pulse returns it to 0.
- ch1 empty for the whole event -> after 1023 empty cycles TIMEOUT_ERROR=1, SEL advances to 2, event completes normally.
- OUT_FIFO_FULL asserted 5 cycles mid-stream and during EMIT -> no IN_RE and no OUT_FIFO_WE while full, no words lost or duplicated, timeout counter does not advance.
- RESET low during ch1 transfer -> all outputs 0 immediately; after release, the next event starts at ch0 with no EE word emitted for the aborted event.
